// File: rtl/batalha_naval_pkg.sv
// Shared encodings and defaults for the Batalha Naval placement path.
package batalha_naval_pkg;

  typedef enum logic {
    ORI_H = 1'b0,
    ORI_V = 1'b1
  } ori_t;

  typedef enum logic {
    ST_MOVE   = 1'b0,
    ST_LOCKED = 1'b1
  } estado_t;

  localparam int GRID_DEF    = 10;
  localparam int COORD_W_DEF = 4;

  localparam int IDX_LEFT  = 0;
  localparam int IDX_RIGHT = 1;
  localparam int IDX_UP    = 2;
  localparam int IDX_DOWN  = 3;
  localparam int IDX_ROT   = 4;
  localparam int IDX_CONF  = 5;
  localparam int IDX_LOAD  = 6;
  localparam int N_ENT     = 7;

endpackage

// File: rtl/sincroniza_borda.sv
// 2-FF synchroniser plus rising-edge pulse for one raw key/switch level.
module sincroniza_borda (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_pulso
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_vld;
  logic r_arm;

  // r_arm stays low until a genuine low level has been synchronised,
  // so a key still held across reset never produces a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_vld  <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_vld  <= 1'b1;
      if (r_vld && !r_s1)
        r_arm <= 1'b1;
    end
  end

  assign o_pulso = r_s2 & ~r_prev & r_arm;

endmodule

// File: rtl/posicionador_embarcacao.sv
// Ship placement controller: moves, rotates, clamps and locks one ship,
// emitting the packed cell coordinates for the drawing modules.
module posicionador_embarcacao
  import batalha_naval_pkg::*;
#(
  parameter int TAM_EMB = 3,
  parameter int GRID    = GRID_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int START_X = 5,
  parameter int START_Y = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           leftArrow,
  input  logic                           rightArrow,
  input  logic                           upArrow,
  input  logic                           downArrow,
  input  logic                           rotate,
  input  logic                           confirm,
  input  logic                           load,
  output logic [2*COORD_W*TAM_EMB-1:0]   posicoesEmbarcacao,
  output logic                           travado,
  output logic                           moveu
);

  generate
    if (TAM_EMB < 1 || TAM_EMB > GRID || GRID > (1 << COORD_W)) begin : g_bad_dim
      $fatal(1, "posicionador_embarcacao: bad TAM_EMB/GRID/COORD_W");
    end
    if (START_X < 0 || START_X > GRID - TAM_EMB ||
        START_Y < 0 || START_Y > GRID - 1) begin : g_bad_start
      $fatal(1, "posicionador_embarcacao: start does not fit");
    end
  endgenerate

  localparam logic [COORD_W-1:0] MAX_T = COORD_W'(GRID - TAM_EMB);
  localparam logic [COORD_W-1:0] MAX_G = COORD_W'(GRID - 1);
  localparam logic [COORD_W-1:0] SX    = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY    = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] ZERO  = '0;

  logic [N_ENT-1:0] w_raw;
  logic [N_ENT-1:0] w_ev;

  assign w_raw = {load, confirm, rotate, downArrow,
                  upArrow, rightArrow, leftArrow};

  generate
    for (genvar g = 0; g < N_ENT; g++) begin : g_sinc
      sincroniza_borda u_sinc (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (w_raw[g]),
        .o_pulso (w_ev[g])
      );
    end
  endgenerate

  logic [COORD_W-1:0] r_ax;
  logic [COORD_W-1:0] r_ay;
  ori_t               r_ori;
  estado_t            r_est;
  logic               r_travado;
  logic               r_moveu;

  logic [3:0]         w_dir;
  logic               w_um_dir;
  logic [COORD_W-1:0] w_max_x;
  logic [COORD_W-1:0] w_max_y;

  assign w_dir    = w_ev[IDX_DOWN:IDX_LEFT];
  assign w_um_dir = $onehot(w_dir);
  assign w_max_x  = (r_ori == ORI_H) ? MAX_T : MAX_G;
  assign w_max_y  = (r_ori == ORI_H) ? MAX_G : MAX_T;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ax      <= SX;
      r_ay      <= SY;
      r_ori     <= ORI_H;
      r_est     <= ST_MOVE;
      r_travado <= 1'b0;
      r_moveu   <= 1'b0;
    end else begin
      r_moveu <= 1'b0;
      if (w_ev[IDX_LOAD]) begin
        r_ax      <= SX;
        r_ay      <= SY;
        r_ori     <= ORI_H;
        r_est     <= ST_MOVE;
        r_travado <= 1'b0;
        r_moveu   <= (r_ax != SX) || (r_ay != SY) || (r_ori != ORI_H);
      end else if (r_est == ST_MOVE) begin
        if (w_ev[IDX_CONF]) begin
          r_est     <= ST_LOCKED;
          r_travado <= 1'b1;
        end else if (w_ev[IDX_ROT]) begin
          r_moveu <= 1'b1;
          // Rotation always succeeds; the axis that grows is clamped.
          if (r_ori == ORI_H) begin
            r_ori <= ORI_V;
            if (r_ay > MAX_T)
              r_ay <= MAX_T;
          end else begin
            r_ori <= ORI_H;
            if (r_ax > MAX_T)
              r_ax <= MAX_T;
          end
        end else if (w_um_dir) begin
          unique case (1'b1)
            w_dir[IDX_LEFT]: if (r_ax != ZERO) begin
              r_ax    <= r_ax - ONE;
              r_moveu <= 1'b1;
            end
            w_dir[IDX_RIGHT]: if (r_ax < w_max_x) begin
              r_ax    <= r_ax + ONE;
              r_moveu <= 1'b1;
            end
            w_dir[IDX_UP]: if (r_ay < w_max_y) begin
              r_ay    <= r_ay + ONE;
              r_moveu <= 1'b1;
            end
            w_dir[IDX_DOWN]: if (r_ay != ZERO) begin
              r_ay    <= r_ay - ONE;
              r_moveu <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign travado = r_travado;
  assign moveu   = r_moveu;

  generate
    for (genvar i = 0; i < TAM_EMB; i++) begin : g_cel
      assign posicoesEmbarcacao[2*COORD_W*i +: COORD_W] =
        (r_ori == ORI_H) ? r_ax + COORD_W'(i) : r_ax;
      assign posicoesEmbarcacao[2*COORD_W*i+COORD_W +: COORD_W] =
        (r_ori == ORI_V) ? r_ay + COORD_W'(i) : r_ay;
    end
  endgenerate

endmodule

// File: tb/tb_posicionador_embarcacao.sv
// Bench for posicionador_embarcacao: press-level model plus directed presses.
module tb_posicionador_embarcacao;

  localparam int TAM = 3;
  localparam int GR  = 10;
  localparam int CW  = 4;
  localparam int SX  = 5;
  localparam int SY  = 5;
  localparam int VW  = 2*CW*TAM;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    raw   = '0;
  logic [VW-1:0] vec;
  logic          travado;
  logic          moveu;

  int n_chk  = 0;
  int n_fail = 0;
  int n_mov  = 0;

  localparam logic [6:0] K_LEFT  = 7'b0000001;
  localparam logic [6:0] K_RIGHT = 7'b0000010;
  localparam logic [6:0] K_UP    = 7'b0000100;
  localparam logic [6:0] K_DOWN  = 7'b0001000;
  localparam logic [6:0] K_ROT   = 7'b0010000;
  localparam logic [6:0] K_CONF  = 7'b0100000;
  localparam logic [6:0] K_LOAD  = 7'b1000000;

  posicionador_embarcacao #(
    .TAM_EMB (TAM), .GRID (GR), .COORD_W (CW),
    .START_X (SX),  .START_Y (SY)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .leftArrow          (raw[0]),
    .rightArrow         (raw[1]),
    .upArrow            (raw[2]),
    .downArrow          (raw[3]),
    .rotate             (raw[4]),
    .confirm            (raw[5]),
    .load               (raw[6]),
    .posicoesEmbarcacao (vec),
    .travado            (travado),
    .moveu              (moveu)
  );

  always #5 clock = ~clock;

  // Model: a press is a 0->1 change of the level seen at successive edges,
  // acted on two edges later. Levels before the first post-reset edge
  // count as high, so a key held through reset is not a press.
  int         m_ax, m_ay;
  bit         m_ori, m_lock, m_moveu;
  bit [6:0]   m_prev, m_p1, m_p2;

  function automatic logic [VW-1:0] cells(int ax, int ay, bit ori);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < TAM; i++) begin
      v[2*CW*i +: CW]      = CW'(ori ? ax : ax + i);
      v[2*CW*i + CW +: CW] = CW'(ori ? ay + i : ay);
    end
    return v;
  endfunction

  function automatic bit fits(int x, int y, bit ori);
    int lx, ly;
    lx = ori ? GR - 1 : GR - TAM;
    ly = ori ? GR - TAM : GR - 1;
    return x >= 0 && x <= lx && y >= 0 && y <= ly;
  endfunction

  task automatic m_apply(input bit [6:0] a);
    int ox, oy, nx, ny;
    bit oo;
    ox = m_ax; oy = m_ay; oo = m_ori;
    if (a[6]) begin
      m_ax = SX; m_ay = SY; m_ori = 0; m_lock = 0;
    end else if (!m_lock) begin
      if (a[5]) m_lock = 1;
      else if (a[4]) begin
        m_ori = !m_ori;
        if (m_ori && m_ay > GR - TAM) m_ay = GR - TAM;
        if (!m_ori && m_ax > GR - TAM) m_ax = GR - TAM;
      end else if ($countones(a[3:0]) == 1) begin
        nx = m_ax - int'(a[0]) + int'(a[1]);
        ny = m_ay + int'(a[2]) - int'(a[3]);
        if (fits(nx, ny, m_ori)) begin
          m_ax = nx; m_ay = ny;
        end
      end
    end
    m_moveu = (ox != m_ax) || (oy != m_ay) || (oo != m_ori);
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_ax = SX; m_ay = SY; m_ori = 0; m_lock = 0; m_moveu = 0;
      m_prev = '1; m_p1 = '0; m_p2 = '0;
    end else begin
      m_apply(m_p2);
      m_p2   = m_p1;
      m_p1   = raw & ~m_prev;
      m_prev = raw;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      n_chk++;
      if (vec !== cells(m_ax, m_ay, m_ori) || travado !== m_lock ||
          moveu !== m_moveu) begin
        n_fail++;
        $display("FAIL model: vec=%h trav=%b mov=%b required vec=%h trav=%b mov=%b",
                 vec, travado, moveu, cells(m_ax, m_ay, m_ori), m_lock, m_moveu);
      end
      if (moveu === 1'b1) n_mov++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [6:0] m, input int hold);
    @(negedge clock); #1 raw = m;
    repeat (hold) @(negedge clock);
    #1 raw = '0;
    repeat (6) @(negedge clock);
  endtask

  int mv0;

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_vec", 32'(vec), 32'h575655);
    check("reset_trav", 32'(travado), 0);
    check("reset_moveu", 32'(moveu), 0);

    // first right press: latency check
    @(negedge clock); #1 raw = K_RIGHT;
    @(negedge clock); #1 raw = '0;
    @(negedge clock);
    check("lat_k1_vec", 32'(vec), 32'h575655);
    @(negedge clock);
    check("lat_k2_vec", 32'(vec), 32'h585756);
    check("lat_k2_moveu", 32'(moveu), 1);
    repeat (5) @(negedge clock);
    press(K_RIGHT, 1);
    press(K_RIGHT, 1);
    check("right_clamp_vec", 32'(vec), 32'h595857);
    check("right_moveu_cnt", 32'(n_mov), 2);

    repeat (4) press(K_UP, 1);
    check("up_to_9_vec", 32'(vec), 32'h999897);
    mv0 = n_mov;
    press(K_ROT, 1);
    check("rot_clamp_vec", 32'(vec), 32'h978777);
    check("rot_moveu_cnt", 32'(n_mov - mv0), 1);

    mv0 = n_mov;
    press(K_LEFT | K_UP, 1);
    check("dual_dir_vec", 32'(vec), 32'h978777);
    check("dual_dir_moveu", 32'(n_mov - mv0), 0);

    press(K_RIGHT, 50);
    check("hold_right_vec", 32'(vec), 32'h988878);
    check("hold_right_moveu", 32'(n_mov - mv0), 1);

    @(negedge clock); #1 raw = K_CONF;
    @(negedge clock); #1 raw = '0;
    @(negedge clock);
    check("conf_k1_trav", 32'(travado), 0);
    @(negedge clock);
    check("conf_k2_trav", 32'(travado), 1);
    repeat (5) @(negedge clock);
    press(K_LEFT, 1);
    press(K_ROT, 1);
    check("locked_vec", 32'(vec), 32'h988878);
    check("locked_trav", 32'(travado), 1);

    mv0 = n_mov;
    press(K_LOAD, 1);
    check("load_vec", 32'(vec), 32'h575655);
    check("load_trav", 32'(travado), 0);
    check("load_moveu", 32'(n_mov - mv0), 1);

    // reset while downArrow sits in the synchroniser
    @(negedge clock); #1 raw = K_DOWN;
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mv0 = n_mov;
    repeat (10) @(negedge clock);
    check("held_rst_vec", 32'(vec), 32'h575655);
    check("held_rst_moveu", 32'(n_mov - mv0), 0);
    #1 raw = '0;
    repeat (3) @(negedge clock);
    press(K_DOWN, 1);
    check("repress_down_vec", 32'(vec), 32'h474645);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
